ethstream_mux: RTL and testbench

Multi-channel successor to the single-stream UDP streamer. It arbitrates NCH outbound AXI4-Stream byte channels onto one UDP transmit interface, with per-channel destination ports and error-abort handling. It also demultiplexes inbound UDP payload to NCH per-channel receive FIFOs by destination port. It sits between the UDP/IP core and NCH user stream endpoints, in the same clock domain.

---
 rtl/ethstream_mux.sv | 256 +++++++++++++++++++++++++
 tb/tb_ethstream_mux.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethstream_mux.sv
`default_nettype none
// ============================================================================
// Module   : ethstream_mux
// Purpose  : Round-robin multiplexer from NCH AXI4-Stream byte channels to one
//            UDP transmit port. Demultiplexes inbound UDP payload by
//            destination port into per-channel FWFT FIFOs.
// Revision : 1.0
// ============================================================================
module ethstream_mux #(
    parameter int          NCH       = 4,
    parameter logic [15:0] BASE_PORT = 16'd5000,
    parameter int          RX_DEPTH  = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stream_linked,
    input  logic [31:0]          stream_ip_addr,
    input  logic                 udp_in_start,
    input  logic                 udp_in_valid,
    input  logic                 udp_in_last,
    input  logic [7:0]           udp_in_data,
    input  logic [15:0]          udp_in_dst_port,
    input  logic                 udp_out_ready,
    input  logic [1:0]           udp_out_result,
    output logic [7:0]           udp_out_data,
    output logic                 udp_out_valid,
    output logic                 udp_out_last,
    output logic                 udp_out_start,
    output logic [31:0]          udp_out_dst_ip_addr,
    output logic [15:0]          udp_out_dst_port,
    output logic [15:0]          udp_out_length,
    input  logic [8*NCH-1:0]     s_axis_tdata,
    input  logic [NCH-1:0]       s_axis_tvalid,
    input  logic [NCH-1:0]       s_axis_tlast,
    output logic [NCH-1:0]       s_axis_tready,
    output logic [8*NCH-1:0]     m_axis_tdata,
    output logic [NCH-1:0]       m_axis_tvalid,
    output logic [NCH-1:0]       m_axis_tlast,
    input  logic [NCH-1:0]       m_axis_tready,
    output logic [15:0]          tx_err_count,
    output logic [NCH-1:0]       rx_overflow
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LSB = 3'd1,
        S_LEN_MSB = 3'd2,
        S_REQUEST = 3'd3,
        S_STREAM  = 3'd4,
        S_DRAIN   = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] ptr_q;
    logic [GW-1:0] ptr_d;
    logic [GW-1:0] pick_d;
    logic          pick_vld_d;
    logic [GW-1:0] idx_d;
    logic [15:0]   len_q;
    logic [15:0]   err_cnt_q;
    logic          start_q;

    logic [7:0]    w_tdata_arr [NCH];
    logic [7:0]    w_tdata_g;
    logic          w_tvalid_g;
    logic          w_tlast_g;
    logic          w_tready_g;

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_tx
        assign w_tdata_arr[i]   = s_axis_tdata[8*i +: 8];
        assign s_axis_tready[i] = (grant_q == GW'(i)) && w_tready_g;
    end

    assign w_tdata_g  = w_tdata_arr[grant_q];
    assign w_tvalid_g = s_axis_tvalid[grant_q];
    assign w_tlast_g  = s_axis_tlast[grant_q];
    assign w_tready_g = (state_q == S_LEN_LSB) || (state_q == S_LEN_MSB) ||
                        (state_q == S_DRAIN) ||
                        ((state_q == S_STREAM) && udp_out_ready);

    // Descending scan so the channel closest to ptr_q is written last and wins.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_d     = ptr_q;
        idx_d      = ptr_q;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx_d = GW'((int'(ptr_q) + k) % NCH);
            if (s_axis_tvalid[idx_d]) begin
                pick_vld_d = 1'b1;
                pick_d     = idx_d;
            end
        end
        ptr_d = GW'((int'(pick_d) + 1) % NCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            len_q     <= '0;
            start_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stream_linked && pick_vld_d) begin
                        grant_q <= pick_d;
                        ptr_q   <= ptr_d;
                        state_q <= S_LEN_LSB;
                    end
                end
                S_LEN_LSB: begin
                    if (w_tvalid_g) begin
                        len_q[7:0] <= w_tdata_g;
                        state_q    <= S_LEN_MSB;
                    end
                end
                S_LEN_MSB: begin
                    if (w_tvalid_g) begin
                        len_q[15:8] <= w_tdata_g;
                        state_q     <= S_REQUEST;
                    end
                end
                S_REQUEST: begin
                    start_q <= 1'b1;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (udp_out_result == 2'b01) begin
                        start_q <= 1'b0;
                    end
                    // A completed final byte takes precedence over a late error.
                    if (w_tvalid_g && udp_out_ready && w_tlast_g) begin
                        start_q <= 1'b0;
                        state_q <= S_FINISH;
                    end else if (udp_out_result == 2'b10) begin
                        start_q <= 1'b0;
                        state_q <= S_DRAIN;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_tvalid_g && w_tlast_g) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign udp_out_data        = w_tdata_g;
    assign udp_out_valid       = (state_q == S_STREAM) && w_tvalid_g;
    assign udp_out_last        = (state_q == S_STREAM) && w_tlast_g;
    assign udp_out_start       = start_q;
    assign udp_out_dst_ip_addr = stream_ip_addr;
    assign udp_out_dst_port    = BASE_PORT + 16'(grant_q);
    assign udp_out_length      = len_q;
    assign tx_err_count        = err_cnt_q;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    logic [15:0]   w_rx_off;
    logic          w_rx_hit;
    logic          rx_act_q;
    logic [GW-1:0] rx_tgt_q;
    logic          w_cur_act;
    logic [GW-1:0] w_cur_tgt;

    // Ports below BASE_PORT wrap to large values and fail the range test.
    assign w_rx_off  = udp_in_dst_port - BASE_PORT;
    assign w_rx_hit  = (w_rx_off < 16'(NCH));
    assign w_cur_act = udp_in_start ? w_rx_hit : rx_act_q;
    assign w_cur_tgt = udp_in_start ? GW'(w_rx_off) : rx_tgt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_act_q <= 1'b0;
            rx_tgt_q <= '0;
        end else begin
            if (udp_in_start) begin
                rx_act_q <= w_rx_hit;
                rx_tgt_q <= GW'(w_rx_off);
            end
            if (udp_in_valid && udp_in_last) begin
                rx_act_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_rx
        logic [8:0]  mem [RX_DEPTH];
        logic [AW:0] wp_q;
        logic [AW:0] rp_q;
        logic        ovf_q;
        logic        w_empty;
        logic        w_full;
        logic        w_rd;
        logic        w_wr_req;
        logic        w_wr;
        logic [8:0]  w_head;

        assign w_empty  = (wp_q == rp_q);
        assign w_full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        assign w_rd     = !w_empty && m_axis_tready[i];
        assign w_wr_req = stream_linked && udp_in_valid && w_cur_act &&
                          (w_cur_tgt == GW'(i));
        // A read in the same cycle frees the slot, so a full FIFO still accepts.
        assign w_wr     = w_wr_req && (!w_full || w_rd);
        assign w_head   = mem[rp_q[AW-1:0]];

        always_ff @(posedge clk) begin
            if (w_wr) begin
                mem[wp_q[AW-1:0]] <= {udp_in_last, udp_in_data};
            end
        end

        always_ff @(posedge clk) begin
            if (reset || !stream_linked) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                if (w_wr) wp_q <= wp_q + 1'b1;
                if (w_rd) rp_q <= rp_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                ovf_q <= 1'b0;
            end else if (w_wr_req && w_full && !w_rd) begin
                ovf_q <= 1'b1;
            end
        end

        assign m_axis_tvalid[i]       = !w_empty;
        assign m_axis_tdata[8*i +: 8] = w_head[7:0];
        assign m_axis_tlast[i]        = w_head[8];
        assign rx_overflow[i]         = ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ethstream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethstream_mux
// Purpose  : Directed self-checking bench for ethstream_mux (TX arbitration,
//            error drain, RX demux, overflow, flush and reset).
// Revision : 1.0
// ============================================================================
module tb_ethstream_mux;

    localparam int          NCH   = 4;
    localparam logic [15:0] BASE  = 16'd5000;
    localparam int          DEPTH = 16;

    typedef logic [7:0] bytes_t[$];

    logic               clk = 1'b0;
    logic               reset;
    logic               stream_linked;
    logic [31:0]        stream_ip_addr;
    logic               udp_in_start, udp_in_valid, udp_in_last;
    logic [7:0]         udp_in_data;
    logic [15:0]        udp_in_dst_port;
    logic               udp_out_ready;
    logic [1:0]         udp_out_result;
    logic [7:0]         udp_out_data;
    logic               udp_out_valid, udp_out_last, udp_out_start;
    logic [31:0]        udp_out_dst_ip_addr;
    logic [15:0]        udp_out_dst_port, udp_out_length;
    logic [8*NCH-1:0]   s_axis_tdata;
    logic [NCH-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [8*NCH-1:0]   m_axis_tdata;
    logic [NCH-1:0]     m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [15:0]        tx_err_count;
    logic [NCH-1:0]     rx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ports[$];
    logic [15:0] lens[$];
    logic [8:0]  obytes[$];
    logic [11:0] rxq[$];

    ethstream_mux #(.NCH(NCH), .BASE_PORT(BASE), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stream_linked(stream_linked),
        .stream_ip_addr(stream_ip_addr),
        .udp_in_start(udp_in_start), .udp_in_valid(udp_in_valid),
        .udp_in_last(udp_in_last), .udp_in_data(udp_in_data),
        .udp_in_dst_port(udp_in_dst_port),
        .udp_out_ready(udp_out_ready), .udp_out_result(udp_out_result),
        .udp_out_data(udp_out_data), .udp_out_valid(udp_out_valid),
        .udp_out_last(udp_out_last), .udp_out_start(udp_out_start),
        .udp_out_dst_ip_addr(udp_out_dst_ip_addr),
        .udp_out_dst_port(udp_out_dst_port), .udp_out_length(udp_out_length),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .tx_err_count(tx_err_count), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ports.delete(); lens.delete(); obytes.delete(); rxq.delete();
    endtask

    task automatic send_frame(input int ch, input bytes_t b, input int budget, output bit ok);
        int  i;
        bit  acc;
        i  = 0;
        ok = 1'b0;
        s_axis_tdata[ch*8 +: 8] = b[0];
        s_axis_tlast[ch]        = (b.size() == 1);
        s_axis_tvalid[ch]       = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            acc = s_axis_tready[ch];
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                if (i == b.size()) begin
                    ok = 1'b1;
                    break;
                end
                s_axis_tdata[ch*8 +: 8] = b[i];
                s_axis_tlast[ch]        = (i == b.size() - 1);
            end
        end
        s_axis_tvalid[ch] = 1'b0;
        s_axis_tlast[ch]  = 1'b0;
    endtask

    task automatic mon_udp(input int n_last, input int budget);
        bit prev;
        int lasts;
        prev  = 1'b0;
        lasts = 0;
        for (int c = 0; c < budget && lasts < n_last; c++) begin
            @(negedge clk);
            if (udp_out_start && !prev) begin
                ports.push_back(udp_out_dst_port);
                lens.push_back(udp_out_length);
            end
            prev = udp_out_start;
            if (udp_out_valid && udp_out_ready) begin
                obytes.push_back({udp_out_last, udp_out_data});
                if (udp_out_last) lasts++;
            end
        end
    endtask

    task automatic inject_err(input int after_n, input int budget);
        int n;
        n = 0;
        for (int c = 0; c < budget && n < after_n; c++) begin
            @(negedge clk);
            if (udp_out_valid && udp_out_ready) n++;
        end
        @(posedge clk);
        #1;
        udp_out_result = 2'b10;
        udp_out_ready  = 1'b0;
        @(posedge clk);
        #1;
        udp_out_result = 2'b00;
        udp_out_ready  = 1'b1;
    endtask

    task automatic rx_send(input logic [15:0] port, input bytes_t b);
        for (int i = 0; i < b.size(); i++) begin
            udp_in_start    = (i == 0);
            udp_in_valid    = 1'b1;
            udp_in_dst_port = port;
            udp_in_data     = b[i];
            udp_in_last     = (i == b.size() - 1);
            @(posedge clk);
            #1;
        end
        udp_in_start = 1'b0;
        udp_in_valid = 1'b0;
        udp_in_last  = 1'b0;
    endtask

    task automatic rx_mon(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_axis_tvalid[ch] && m_axis_tready[ch]) begin
                    rxq.push_back({3'(ch), m_axis_tlast[ch], m_axis_tdata[ch*8 +: 8]});
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({s_axis_tready, udp_out_start, udp_out_valid, udp_out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: tready=%b start=%b valid=%b last=%b, want all 0",
                     s_axis_tready, udp_out_start, udp_out_valid, udp_out_last);
        end
        n_checks++;
        if (udp_out_length !== 16'd0 || udp_out_dst_port !== 16'd5000) begin
            n_fail++;
            $display("FAIL reset_len_port: len=%0d port=%0d, want 0 5000", udp_out_length, udp_out_dst_port);
        end
        n_checks++;
        if (m_axis_tvalid !== '0 || tx_err_count !== 16'd0 || rx_overflow !== '0) begin
            n_fail++;
            $display("FAIL reset_status: mvalid=%b err=%0d ovf=%b, want 0 0 0",
                     m_axis_tvalid, tx_err_count, rx_overflow);
        end
    endtask

    task automatic test_single();
        bytes_t f;
        bit ok;
        do_reset();
        f = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        fork
            send_frame(1, f, 50, ok);
            mon_udp(1, 50);
        join
        n_checks++;
        if (ok !== 1'b1 || ports.size() != 1) begin
            n_fail++;
            $display("FAIL single_done: ok=%0d starts=%0d, want 1 1", ok, ports.size());
        end else begin
            n_checks++;
            if (ports[0] !== 16'd5001 || lens[0] !== 16'd2) begin
                n_fail++;
                $display("FAIL single_hdr: port=%0d len=%0d, want 5001 2", ports[0], lens[0]);
            end
        end
        n_checks++;
        if (obytes.size() != 2) begin
            n_fail++;
            $display("FAIL single_count: got %0d bytes, want 2", obytes.size());
        end else begin
            n_checks++;
            if (obytes[0] !== 9'h0AA || obytes[1] !== 9'h1BB) begin
                n_fail++;
                $display("FAIL single_data: got %h %h, want 0aa 1bb", obytes[0], obytes[1]);
            end
        end
        n_checks++;
        if (udp_out_dst_ip_addr !== 32'hC0A8_0102) begin
            n_fail++;
            $display("FAIL single_ip: got %h, want c0a80102", udp_out_dst_ip_addr);
        end
    endtask

    task automatic test_round_robin();
        bit ok0, ok2;
        bit okc;
        bytes_t f;
        do_reset();
        ok0 = 1'b1;
        ok2 = 1'b1;
        fork
            begin
                for (int p = 0; p < 3; p++) begin
                    f = '{8'h01, 8'h00, 8'(p)};
                    send_frame(0, f, 60, okc);
                    ok0 = ok0 & okc;
                end
            end
            begin
                for (int p = 0; p < 3; p++) begin
                    send_frame(2, '{8'h01, 8'h00, 8'(8'h20 + p)}, 60, okc);
                    ok2 = ok2 & okc;
                end
            end
            mon_udp(6, 200);
        join
        n_checks++;
        if (!(ok0 && ok2) || ports.size() != 6 || obytes.size() != 6) begin
            n_fail++;
            $display("FAIL rr_count: ok0=%0d ok2=%0d starts=%0d bytes=%0d, want 1 1 6 6",
                     ok0, ok2, ports.size(), obytes.size());
        end
        for (int k = 0; k < ports.size() && k < obytes.size(); k++) begin
            n_checks++;
            if (ports[k] !== ((k % 2 == 0) ? 16'd5000 : 16'd5002) ||
                obytes[k] !== {1'b1, ((k % 2 == 0) ? 8'(k / 2) : 8'(8'h20 + k / 2))}) begin
                n_fail++;
                $display("FAIL rr_pkt%0d: port=%0d byte=%h", k, ports[k], obytes[k]);
            end
        end
    endtask

    task automatic test_error_drain();
        bytes_t f1;
        bytes_t f2;
        bit ok1, ok2;
        do_reset();
        f1 = '{8'h08, 8'h00, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
        f2 = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        fork
            begin
                send_frame(1, f1, 60, ok1);
                send_frame(1, f2, 60, ok2);
            end
            inject_err(3, 60);
            mon_udp(1, 150);
        join
        n_checks++;
        if (ok1 !== 1'b1 || ok2 !== 1'b1) begin
            n_fail++;
            $display("FAIL err_frames: aborted_done=%0d next_done=%0d, want 1 1", ok1, ok2);
        end
        n_checks++;
        if (tx_err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL err_count: got %0d, want 1", tx_err_count);
        end
        n_checks++;
        if (obytes.size() != 5) begin
            n_fail++;
            $display("FAIL err_bytes: got %0d udp bytes, want 5", obytes.size());
        end else begin
            n_checks++;
            if (obytes[2] !== 9'h052 || obytes[3] !== 9'h0AA || obytes[4] !== 9'h1BB) begin
                n_fail++;
                $display("FAIL err_data: got %h %h %h, want 052 0aa 1bb", obytes[2], obytes[3], obytes[4]);
            end
        end
        n_checks++;
        if (ports.size() != 2 || lens.size() != 2 || lens[1] !== 16'd2) begin
            n_fail++;
            $display("FAIL err_starts: starts=%0d, want 2 with second len 2", ports.size());
        end
    endtask

    task automatic test_rx_demux();
        do_reset();
        m_axis_tready = '1;
        fork
            rx_send(16'd5003, '{8'h11, 8'h22, 8'h33, 8'h44});
            rx_mon(10);
        join
        n_checks++;
        if (rxq.size() != 4) begin
            n_fail++;
            $display("FAIL rx_count: got %0d, want 4", rxq.size());
        end else begin
            n_checks++;
            if (rxq[0] !== 12'h611 || rxq[1] !== 12'h622 || rxq[2] !== 12'h633 || rxq[3] !== 12'h744) begin
                n_fail++;
                $display("FAIL rx_data: got %h %h %h %h, want 611 622 633 744",
                         rxq[0], rxq[1], rxq[2], rxq[3]);
            end
        end
        rxq.delete();
        fork
            rx_send(16'd4999, '{8'h01, 8'h02, 8'h03});
            rx_mon(6);
        join
        n_checks++;
        if (rxq.size() != 0 || rx_overflow !== '0) begin
            n_fail++;
            $display("FAIL rx_discard: got %0d bytes ovf=%b, want 0 0", rxq.size(), rx_overflow);
        end
    endtask

    task automatic test_overflow();
        bytes_t b;
        do_reset();
        m_axis_tready = '0;
        for (int i = 0; i < DEPTH + 3; i++) b.push_back(8'(i));
        rx_send(16'd5000, b);
        n_checks++;
        if (m_axis_tvalid !== 4'b0001 || rx_overflow !== 4'b0001) begin
            n_fail++;
            $display("FAIL ovf_flags: mvalid=%b ovf=%b, want 0001 0001", m_axis_tvalid, rx_overflow);
        end
        m_axis_tready = '1;
        rx_mon(DEPTH + 4);
        n_checks++;
        if (rxq.size() != DEPTH) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d, want %0d", rxq.size(), DEPTH);
        end else begin
            n_checks++;
            if (rxq[0] !== 12'h000 || rxq[DEPTH-1] !== 12'(DEPTH - 1)) begin
                n_fail++;
                $display("FAIL ovf_data: first=%h last=%h, want 000 %h", rxq[0], rxq[DEPTH-1], 12'(DEPTH - 1));
            end
        end
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        m_axis_tready = '0;
        rx_send(16'd5002, '{8'h01, 8'h02, 8'h03});
        n_checks++;
        if (m_axis_tvalid !== 4'b0100) begin
            n_fail++;
            $display("FAIL flush_pre: mvalid=%b, want 0100", m_axis_tvalid);
        end
        stream_linked = 1'b0;
        @(posedge clk);
        #1;
        stream_linked = 1'b1;
        n_checks++;
        if (m_axis_tvalid !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush: mvalid=%b, want 0000", m_axis_tvalid);
        end
        udp_out_ready         = 1'b0;
        s_axis_tdata[7:0]     = 8'h06;
        s_axis_tlast[0]       = 1'b0;
        s_axis_tvalid[0]      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (udp_out_valid !== 1'b1 || udp_out_start !== 1'b1 || udp_out_length !== 16'h0606) begin
            n_fail++;
            $display("FAIL stream_state: valid=%b start=%b len=%h, want 1 1 0606",
                     udp_out_valid, udp_out_start, udp_out_length);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({s_axis_tready, udp_out_start, udp_out_valid, udp_out_last} !== '0 ||
            udp_out_length !== 16'd0 || udp_out_dst_port !== 16'd5000) begin
            n_fail++;
            $display("FAIL reset_mid: tready=%b start=%b valid=%b len=%h port=%0d, want 0 0 0 0000 5000",
                     s_axis_tready, udp_out_start, udp_out_valid, udp_out_length, udp_out_dst_port);
        end
        s_axis_tvalid[0] = 1'b0;
        reset            = 1'b0;
        udp_out_ready    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        stream_linked   = 1'b1;
        stream_ip_addr  = 32'hC0A8_0102;
        udp_in_start    = 1'b0;
        udp_in_valid    = 1'b0;
        udp_in_last     = 1'b0;
        udp_in_data     = 8'h00;
        udp_in_dst_port = 16'd0;
        udp_out_ready   = 1'b1;
        udp_out_result  = 2'b00;
        s_axis_tdata    = '0;
        s_axis_tvalid   = '0;
        s_axis_tlast    = '0;
        m_axis_tready   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_error_drain();
        test_rx_demux();
        test_overflow();
        test_flush_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
